// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq.
// master drives operations and consumes results; slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags {N,V,C,Z}.
// Single-cycle logic ops, WIDTH-cycle shift-add multiply.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_ORR = 3'b101;
  localparam logic [2:0] OP_ANR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;
  logic               out_valid_q;
  logic               take;

  logic [WIDTH-1:0]   bb;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_nxt;

  assign bus.in_ready  = rst_n && (state == IDLE)
                      && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign take          = bus.in_valid && bus.in_ready;

  always_comb begin
    bb      = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    sum     = {1'b0, bus.a} + {1'b0, bb}
            + {{WIDTH{1'b0}}, bus.op == OP_SUB};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (1'b1)
      (bus.op == OP_ADD),
      (bus.op == OP_SUB): begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        // Overflow judged on the operand actually fed to the adder.
        alu_v   = (bus.a[WIDTH-1] == bb[WIDTH-1])
               && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      (bus.op == OP_OR):  alu_res = bus.a | bus.b;
      (bus.op == OP_AND): alu_res = bus.a & bus.b;
      (bus.op == OP_XOR): alu_res = bus.a ^ bus.b;
      (bus.op == OP_ORR):
        alu_res = {{(WIDTH-1){1'b0}}, |(bus.a | bus.b)};
      (bus.op == OP_ANR):
        alu_res = {{(WIDTH-1){1'b0}}, &(bus.a & bus.b)};
      default: alu_res = '0;
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mcand       <= '0;
      acc         <= '0;
      mplier      <= '0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take && bus.op == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end else if (take) begin
            result_q    <= alu_res;
            flags_q     <= {alu_res[WIDTH-1], alu_v, alu_c,
                            alu_res == '0};
            out_valid_q <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == LAST) begin
            result_q    <= acc_nxt[WIDTH-1:0];
            flags_q     <= {acc_nxt[WIDTH-1], 1'b0,
                            |acc_nxt[2*WIDTH-1:WIDTH],
                            acc_nxt[WIDTH-1:0] == '0};
            out_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=8 main instance plus a
// WIDTH=16 instance for the wide multiply.
module tb_alu_seq;
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] OR_ = 3'b010;
  localparam logic [2:0] AND_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100;
  localparam logic [2:0] ORR = 3'b101;
  localparam logic [2:0] ANR = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  m8 ();
  alu_seq_if #(.WIDTH(16)) m16 ();

  alu_seq #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m16)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Holds the op until accepted; returns at the negedge after
  // the accepting edge with the inputs still driven.
  task automatic send(input logic [2:0] o, input logic [7:0] x,
                      input logic [7:0] y);
    bit ok;
    bit rdy;
    ok = 1'b0;
    m8.in_valid = 1'b1;
    m8.op = o;
    m8.a = x;
    m8.b = y;
    for (int i = 0; i < 50 && !ok; i++) begin
      rdy = m8.in_ready;
      @(posedge clk);
      ok = rdy;
      @(negedge clk);
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic expect8(input string tag, input logic [7:0] r,
                         input logic [3:0] f);
    chk({tag, "_valid"}, m8.out_valid, 1);
    chk({tag, "_res"}, m8.result, r);
    chk({tag, "_flags"}, m8.flags, f);
  endtask

  task automatic mul_wait8();
    m8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", {m8.in_ready, m8.out_valid}, 2'b00);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int late;
    m8.in_valid = 0; m8.op = 0; m8.a = 0; m8.b = 0;
    m8.out_ready = 1;
    m16.in_valid = 0; m16.op = 0; m16.a = 0; m16.b = 0;
    m16.out_ready = 1;

    repeat (2) @(negedge clk);
    chk("rst_valid", m8.out_valid, 0);
    chk("rst_res", m8.result, 0);
    chk("rst_flags", m8.flags, 0);
    chk("rst_rdy", m8.in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", m8.in_ready, 1);

    send(ADD, 8'hFF, 8'h01); expect8("add", 8'h00, 4'b0011);
    send(SUB, 8'h80, 8'h01); expect8("sub1", 8'h7F, 4'b0110);
    send(SUB, 8'h01, 8'h02); expect8("sub2", 8'hFF, 4'b1000);
    send(ORR, 8'h00, 8'h00); expect8("orr0", 8'h00, 4'b0001);
    send(ANR, 8'hFF, 8'hFF); expect8("anr1", 8'h01, 4'b0000);
    send(ANR, 8'hFF, 8'h7F); expect8("anr0", 8'h00, 4'b0001);

    send(MUL, 8'h0F, 8'h11); mul_wait8();
    expect8("mul1", 8'hFF, 4'b1000);
    send(MUL, 8'h10, 8'h10); mul_wait8();
    expect8("mul2", 8'h00, 4'b0011);

    chk("w16_rdy", m16.in_ready, 1);
    m16.in_valid = 1; m16.op = MUL;
    m16.a = 16'h00FF; m16.b = 16'h0101;
    @(posedge clk);
    @(negedge clk);
    m16.in_valid = 0;
    for (int i = 0; i < 16; i++) begin
      chk("w16_busy", {m16.in_ready, m16.out_valid}, 2'b00);
      @(negedge clk);
    end
    chk("w16_valid", m16.out_valid, 1);
    chk("w16_res", m16.result, 16'hFFFF);
    chk("w16_flags", m16.flags, 4'b1000);

    m8.in_valid = 0;
    @(negedge clk);
    m8.out_ready = 0;
    send(XOR_, 8'hAA, 8'h0F); expect8("bp_xor", 8'hA5, 4'b1000);
    m8.in_valid = 1; m8.op = OR_; m8.a = 8'h0F; m8.b = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_res", m8.result, 8'hA5);
      chk("bp_hold_vr", {m8.out_valid, m8.in_ready}, 2'b10);
      @(negedge clk);
    end
    m8.out_ready = 1;
    send(OR_, 8'h0F, 8'hF0); expect8("bp_or", 8'hFF, 4'b1000);
    send(AND_, 8'h0F, 8'h3C); expect8("b2b_and", 8'h0C, 4'b0000);
    send(ADD, 8'h7F, 8'h01); expect8("b2b_add", 8'h80, 4'b1100);

    send(MUL, 8'h03, 8'h05);
    m8.in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", m8.out_valid, 0);
    chk("mrst_res", m8.result, 0);
    chk("mrst_flags", m8.flags, 0);
    chk("mrst_rdy", m8.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    late = 0;
    repeat (12) begin
      @(negedge clk);
      if (m8.out_valid) late++;
    end
    chk("no_late", late, 0);
    send(ADD, 8'h02, 8'h03); expect8("post_rst_add", 8'h05, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Accepts one operation per transfer on a valid/ready input channel and returns a registered result plus status flags on a valid/ready output channel.
- Adds a multi-cycle shift-add multiply.
- Sits between the operand/opcode decode stage and result writeback, in place of the combinational unit.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2–64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  op, a, b are valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  3  operation select (encoding below).
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  downstream consumes the result this cycle.
- result  output  WIDTH  operation result.
- flags  output  4  {N, V, C, Z}.

## Operation
- Opcode encoding (all 8 codes distinct):
  - 000 add: a+b.
  - 001 sub: a+~b+1.
  - 010 or: a|b.
  - 011 and: a&b.
  - 100 xor: a^b.
  - 101 or-reduce: zero-extended |(a|b).
  - 110 and-reduce: zero-extended &(a&b).
  - 111 mul: low WIDTH bits of a*b, unsigned.
- Input transfer occurs when in_valid && in_ready at a rising edge. op, a and b are captured at that edge; later changes on the inputs are ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is forced 0 while rst_n is low.
- FSM states:
  - IDLE: on a transfer with op≠111, load result/flags and set out_valid; stay in IDLE. On a transfer with op==111, load multiplicand/multiplier, clear the accumulator and cnt, and go to MUL.
  - MUL: each edge, add the shifted multiplicand when the current multiplier bit is 1, and increment cnt. On the edge processing bit WIDTH-1, load result/flags, set out_valid, and go to IDLE.
- Accumulator is 2·WIDTH bits; cnt is ceil(log2(WIDTH)) bits, with no wrap beyond WIDTH-1.
- Output register: out_valid clears on an edge with out_ready=1 unless a new result loads on that same edge. With out_valid=1 and out_ready=0, result and flags hold stable.
- Flags (computed on the WIDTH-bit result):
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C:
    - add: carry out.
    - sub: carry out of a+~b+1 (1 = no borrow, a≥b unsigned).
    - mul: 1 if the upper WIDTH bits of the product are nonzero.
    - otherwise: 0.
  - V:
    - add/sub: signed overflow (operand signs as applied to the adder, result sign differs).
    - otherwise: 0.
- Reduction ops produce result[0] = the reduced bit, all other bits 0, so N=0.

## Timing
- Reset values: out_valid=0, result=0, flags=4'b0000, state=IDLE, cnt=0. in_ready=0 while rst_n is low and 1 from the first cycle after release.
- Single-cycle ops: accepted at edge k, out_valid=1 after edge k+1. Full throughput of one op per cycle when out_ready stays 1.
- mul: accepted at edge k, out_valid=1 after edge k+WIDTH. in_ready=0 during edges k+1..k+WIDTH. Back-to-back multiplies therefore achieve one per WIDTH+1 cycles.
- Simultaneous events: when out_ready and in_valid are both asserted with out_valid=1, the old result is consumed and the new op is accepted on the same edge. No bubble.
- Reset asserted mid-MUL or with a pending result: all state returns to reset values immediately. The pending result is discarded, and no out_valid pulse appears after release.
- A transfer with in_valid=1 while in_ready=0 is not accepted. Upstream must hold the operation until in_ready=1.

## Test plan
- WIDTH=8, add a=0xFF b=0x01 -> result 0x00, flags N0 V0 C1 Z1, out_valid one cycle after acceptance.
- sub a=0x80 b=0x01 -> 0x7F, N0 V1 C1 Z0. Then sub a=0x01 b=0x02 -> 0xFF, N1 V0 C0 Z0.
- mul 0x0F×0x11 -> 0xFF, C0, out_valid exactly 8 edges after acceptance, in_ready=0 throughout. Then mul 0x10×0x10 -> 0x00, C1 Z1. Rerun with WIDTH=16: 0x00FF×0x0101 -> 0xFFFF after 16 edges.
- Backpressure: out_ready=0, xor 0xAA^0x0F -> 0xA5 held stable for 5 cycles with in_ready=0 and the next op (or 0x0F|0xF0) stalled. Raise out_ready -> 0xA5 consumed and 0xFF appears on the next cycle, followed by back-to-back ops with no bubble.
- Reductions: op 101 with a=0x00 b=0x00 -> 0x00 Z1. op 110 with a=0xFF b=0xFF -> 0x01 Z0. op 110 with a=0xFF b=0x7F -> 0x00 Z1.
- Drop rst_n for 1 cycle at the 3rd MUL cycle -> out_valid, result and flags all 0 immediately, no late result. After release, add 0x02+0x03 -> 0x05 with normal latency.
